// File: rtl/pll_reconfig_seq_pkg.sv
// Shared constants, state encoding and write-table lookup for the
// PLL reconfiguration sequencer (NTSC/PAL colour-burst clock).
package pll_reconfig_seq_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C     = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;

  localparam logic [31:0] MODE_WAITREQ = 32'h0000_0000;
  localparam logic [31:0] N_BYPASS     = 32'h0001_0000;
  localparam logic [31:0] M_4_4        = 32'h0000_0404;
  localparam logic [31:0] START_GO     = 32'h0000_0001;

  localparam logic [31:0] K_NTSC  = 32'd385566516;
  localparam logic [31:0] K_PAL   = 32'd373321139;
  localparam logic [31:0] C0_NTSC = 32'h0002_3938;
  localparam logic [31:0] C0_PAL  = 32'h0000_3939;

  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_NEXT,
    S_WAIT_LOCK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_ent_t;

  function automatic wr_ent_t tbl_entry(
    input logic [2:0] idx,
    input logic       pal
  );
    wr_ent_t e;
    e = '{addr: ADDR_MODE, data: MODE_WAITREQ};
    case (idx)
      3'd0: e = '{addr: ADDR_MODE, data: MODE_WAITREQ};
      3'd1: e = '{addr: ADDR_N, data: N_BYPASS};
      3'd2: e = '{addr: ADDR_M, data: M_4_4};
      3'd3: e = '{addr: ADDR_K,
                  data: pal ? K_PAL : K_NTSC};
      3'd4: e = '{addr: ADDR_C,
                  data: pal ? C0_PAL : C0_NTSC};
      3'd5: e = '{addr: ADDR_START, data: START_GO};
      default: e = '{addr: ADDR_MODE, data: MODE_WAITREQ};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Control, Avalon-MM management and status signals of the sequencer.
interface pll_reconfig_seq_if;
  import pll_reconfig_seq_pkg::*;

  logic        req;
  logic        cfg_sel;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output req,
    output cfg_sel,
    output mgmt_waitrequest,
    output pll_locked,
    input  mgmt_address,
    input  mgmt_writedata,
    input  mgmt_write,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  req,
    input  cfg_sel,
    input  mgmt_waitrequest,
    input  pll_locked,
    output mgmt_address,
    output mgmt_writedata,
    output mgmt_write,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/pll_reconfig_seq.sv
// Sequences the six reconfiguration-core writes that retune the PLL
// to NTSC or PAL, then waits (bounded) for the PLL to relock.
module pll_reconfig_seq
  import pll_reconfig_seq_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1048576
) (
  input logic               clk,
  input logic               rst,
  pll_reconfig_seq_if.slave bus
);

  localparam int CLOG = $clog2(LOCK_TIMEOUT);
  localparam int CW   = (CLOG < 5) ? 5 : CLOG;
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] WIN_END = CW'(15);

  state_t        r_state;
  logic [2:0]    r_idx;
  logic          r_sel;
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic [5:0]    r_address;
  logic [31:0]   r_writedata;
  logic          r_write;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic [2:0] w_idx_nxt;
  wr_ent_t    w_first;
  wr_ent_t    w_next;
  logic       w_win_end;
  logic       w_tmo;

  assign w_idx_nxt = 3'(r_idx + 3'd1);
  assign w_first   = tbl_entry(3'd0, bus.cfg_sel);
  assign w_next    = tbl_entry(w_idx_nxt, r_sel);
  assign w_win_end = (r_cnt == WIN_END);
  assign w_tmo     = (r_cnt == CNT_MAX);

  assign bus.mgmt_address   = r_address;
  assign bus.mgmt_writedata = r_writedata;
  assign bus.mgmt_write     = r_write;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.error          = r_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_sel       <= 1'b0;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_address   <= '0;
      r_writedata <= '0;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_sel       <= bus.cfg_sel;
            r_error     <= 1'b0;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_write     <= 1'b1;
            r_address   <= w_first.addr;
            r_writedata <= w_first.data;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!bus.mgmt_waitrequest) begin
            r_write <= 1'b0;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_state <= S_WAIT_LOCK;
          end else begin
            r_idx       <= w_idx_nxt;
            r_write     <= 1'b1;
            r_address   <= w_next.addr;
            r_writedata <= w_next.data;
            r_state     <= S_WRITE;
          end
        end
        S_WAIT_LOCK: begin
          if (!w_tmo) r_cnt <= r_cnt + 1'b1;
          // Arm once lock has dropped or the 16-cycle window ran out.
          if ((r_armed || w_win_end) && bus.pll_locked) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!bus.pll_locked || w_win_end) begin
            r_armed <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench: expected writes are queued at request time and
// popped by a monitor on every accepted management write.
module tb_pll_reconfig_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  pll_reconfig_seq_if bus ();

  pll_reconfig_seq #(.LOCK_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int nchk = 0;
  int npass = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int m_hold = 0;
  int m_acc = 0;
  int stall_cnt = 0;
  bit stall_en = 0;
  bit start_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mgmt_write && bus.mgmt_address == 6'd4) m_hold++;
      if (bus.mgmt_write && !bus.mgmt_waitrequest) begin
        wr_cnt++;
        if (bus.mgmt_address == 6'd4) m_acc++;
        if (bus.mgmt_address == 6'd2) start_seen = 1;
        if (exp_q.size() == 0) begin
          nchk++;
          $display("FAIL unexpected_write: got addr %0d data %h want none",
                   bus.mgmt_address, bus.mgmt_writedata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.mgmt_address), 32'(mon_e.a));
          chk("wr_data", bus.mgmt_writedata, mon_e.d);
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_en && bus.mgmt_write && bus.mgmt_address == 6'd4
        && stall_cnt < 3) begin
      bus.mgmt_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      bus.mgmt_waitrequest = 1'b0;
    end
  end

  task automatic push_seq(input logic sel);
    exp_q.push_back('{6'd0, 32'h0000_0000});
    exp_q.push_back('{6'd3, 32'h0001_0000});
    exp_q.push_back('{6'd4, 32'h0000_0404});
    exp_q.push_back('{6'd7, sel ? 32'd373321139 : 32'd385566516});
    exp_q.push_back('{6'd5, sel ? 32'h0000_3939 : 32'h0002_3938});
    exp_q.push_back('{6'd2, 32'h0000_0001});
  endtask

  task automatic pulse_req(input logic sel);
    start_seen = 0;
    @(posedge clk); #1;
    bus.cfg_sel = sel;
    bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic wait_end(input int maxc, output int cyc,
                          output bit gd, output bit ge);
    gd = 0; ge = 0; cyc = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk); #1;
      cyc = i;
      if (bus.done) begin gd = 1; break; end
      if (bus.error) begin ge = 1; break; end
    end
  endtask

  // mode 0: lock drops then returns, 1: never drops, 2: stays low
  task automatic run_seq(input logic sel, input int mode,
                         input bit extra, output int cyc,
                         output bit gd, output bit ge);
    bit ok;
    gd = 0; ge = 0; cyc = 0;
    push_seq(sel);
    done_cnt = 0;
    pulse_req(sel);
    chk("busy_after_req", 32'(bus.busy), 32'd1);
    chk("err_cleared", 32'(bus.error), 32'd0);
    if (extra) begin
      repeat (3) @(posedge clk);
      #1;
      bus.cfg_sel = ~sel;
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (start_seen) begin ok = 1; break; end
    end
    chk("start_write_seen", 32'(ok), 32'd1);
    if (ok) begin
      if (mode == 0) begin
        @(posedge clk); #1;
        bus.pll_locked = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.pll_locked = 1'b1;
      end else if (mode == 2) begin
        @(posedge clk); #1;
        bus.pll_locked = 1'b0;
      end
      wait_end(200, cyc, gd, ge);
    end
  endtask

  int  cyc;
  bit  gd;
  bit  ge;
  int  wsnap;
  bit  found;

  initial begin
    bus.req = 1'b0;
    bus.cfg_sel = 1'b0;
    bus.pll_locked = 1'b1;
    bus.mgmt_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_write", 32'(bus.mgmt_write), 32'd0);
    chk("rst_addr", 32'(bus.mgmt_address), 32'd0);
    chk("rst_data", bus.mgmt_writedata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic NTSC
    run_seq(1'b0, 0, 1'b0, cyc, gd, ge);
    chk("ntsc_done", 32'(gd), 32'd1);
    @(negedge clk);
    chk("ntsc_busy_end", 32'(bus.busy), 32'd0);
    chk("ntsc_done_pulse", 32'(bus.done), 32'd0);
    chk("ntsc_done_cnt", 32'(done_cnt), 32'd1);
    chk("ntsc_q_empty", 32'(exp_q.size()), 32'd0);

    // stall on the M write
    stall_en = 1; stall_cnt = 0; m_hold = 0; m_acc = 0;
    run_seq(1'b0, 0, 1'b0, cyc, gd, ge);
    stall_en = 0;
    chk("stall_done", 32'(gd), 32'd1);
    chk("stall_hold_cycles", 32'(m_hold), 32'd4);
    chk("stall_accepts", 32'(m_acc), 32'd1);
    chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // lock timeout
    run_seq(1'b0, 2, 1'b0, cyc, gd, ge);
    chk("tmo_error", 32'(ge), 32'd1);
    chk("tmo_window", 32'(cyc >= 62 && cyc <= 68), 32'd1);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", 32'(bus.error), 32'd1);
    chk("tmo_no_done", 32'(done_cnt), 32'd0);
    bus.pll_locked = 1'b1;

    // PAL with ignored second request; req clears error
    run_seq(1'b1, 0, 1'b1, cyc, gd, ge);
    chk("pal_done", 32'(gd), 32'd1);
    repeat (30) @(negedge clk);
    chk("pal_done_cnt", 32'(done_cnt), 32'd1);
    chk("pal_q_empty", 32'(exp_q.size()), 32'd0);
    chk("pal_idle", 32'(bus.busy), 32'd0);

    // reset during the K write
    push_seq(1'b0);
    pulse_req(1'b0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus.mgmt_write && bus.mgmt_address == 6'd7) begin
        found = 1; break;
      end
    end
    chk("k_write_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_write", 32'(bus.mgmt_write), 32'd0);
    chk("mrst_addr", 32'(bus.mgmt_address), 32'd0);
    chk("mrst_data", bus.mgmt_writedata, 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_error", 32'(bus.error), 32'd0);
    exp_q.delete();
    wsnap = wr_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mrst_no_writes", 32'(wr_cnt - wsnap), 32'd0);
    chk("mrst_still_idle", 32'(bus.busy), 32'd0);

    // lock never drops
    run_seq(1'b0, 1, 1'b0, cyc, gd, ge);
    chk("nodrop_done", 32'(gd), 32'd1);
    chk("nodrop_latency", 32'(cyc >= 16 && cyc <= 18), 32'd1);
    chk("nodrop_q_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
